register_file_mp: RTL and testbench

Parametrised multi-port register file for the MiniMicro pipeline, and the successor to the single-write, two-read register file. Depth, width and read-port count are generic. There are two write ports: the ALU result and the load writeback. The top register is still the PC read-through (PC + offset), and writes to it raise a registered redirect to the fetch stage. A per-register pending-write scoreboard and an NZCV status register give decode the hazard and flag state it needs.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/register_file_mp_if.sv | 41 ++++
 rtl/regfile_scoreboard.sv | 35 +++
 rtl/register_file_mp.sv | 118 +++++++++++
 tb/tb_register_file_mp.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the MiniMicro multi-port register file:
// NZCV flag bit positions, the flags vector type and default geometry.
package regfile_pkg;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   typedef logic [3:0] flags_t;

   localparam int unsigned DATA_W_DEF    = 32;
   localparam int unsigned NUM_REGS_DEF  = 16;
   localparam int unsigned NUM_RD_DEF    = 3;
   localparam int unsigned PC_OFFSET_DEF = 8;

endpackage

// File: rtl/register_file_mp_if.sv
// Pipeline-side bundle for register_file_mp: read ports, two write ports,
// issue marking, flags and the PC redirect / conflict pulses.
interface register_file_mp_if
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned NUM_REGS = NUM_REGS_DEF,
   parameter int unsigned NUM_RD   = NUM_RD_DEF,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
);
   logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
   logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]             rd_ready;
   logic [DATA_W-1:0]             pc_in;
   logic                          wa_en;
   logic [ADDR_W-1:0]             wa_addr;
   logic [DATA_W-1:0]             wa_data;
   logic                          wb_en;
   logic [ADDR_W-1:0]             wb_addr;
   logic [DATA_W-1:0]             wb_data;
   logic                          iss_en;
   logic [ADDR_W-1:0]             iss_addr;
   logic                          flags_we;
   flags_t                        flags_in;
   flags_t                        flags_out;
   logic                          pc_wr_valid;
   logic [DATA_W-1:0]             pc_wr_data;
   logic                          wr_conflict;

   modport master (
      output rd_addr, pc_in, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
             iss_en, iss_addr, flags_we, flags_in,
      input  rd_data, rd_ready, flags_out, pc_wr_valid, pc_wr_data, wr_conflict
   );

   modport slave (
      input  rd_addr, pc_in, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
             iss_en, iss_addr, flags_we, flags_in,
      output rd_data, rd_ready, flags_out, pc_wr_valid, pc_wr_data, wr_conflict
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per data register (PC alias has none).
// Issue sets, any write clears, issue wins when both hit the same register.
module regfile_scoreboard #(
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_iss_en,
   input  logic [ADDR_W-1:0]     i_iss_addr,
   input  logic                  i_wa_en,
   input  logic [ADDR_W-1:0]     i_wa_addr,
   input  logic                  i_wb_en,
   input  logic [ADDR_W-1:0]     i_wb_addr,
   output logic [NUM_REGS-2:0]   o_busy
);
   logic [NUM_REGS-2:0] r_busy;

   // Busy-bit update; an issue to the PC alias matches no entry and is dropped.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_busy <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
            if (i_iss_en && (i_iss_addr == ADDR_W'(i)))
               r_busy[i] <= 1'b1;
            else if ((i_wa_en && (i_wa_addr == ADDR_W'(i))) ||
                     (i_wb_en && (i_wb_addr == ADDR_W'(i))))
               r_busy[i] <= 1'b0;
         end
      end
   end

   assign o_busy = r_busy;
endmodule

// File: rtl/register_file_mp.sv
// MiniMicro multi-port register file: NUM_REGS-1 data registers plus a PC
// read-through alias at the top index, two write ports (A has priority),
// pending-write scoreboard, NZCV flags and registered PC redirect.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module register_file_mp
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned NUM_REGS  = NUM_REGS_DEF,
   parameter int unsigned NUM_RD    = NUM_RD_DEF,
   parameter int unsigned PC_OFFSET = PC_OFFSET_DEF,
   parameter int unsigned ADDR_W    = $clog2(NUM_REGS)
) (
   input  logic               clk,
   input  logic               rst,
   register_file_mp_if.slave  bus
);
   localparam int unsigned       NUM_DATA = NUM_REGS - 1;
   localparam logic [ADDR_W-1:0] PC_IDX   = ADDR_W'(NUM_REGS - 1);

   logic [DATA_W-1:0]             r_regs [NUM_DATA];
   flags_t                        r_flags;
   logic                          r_pc_wr_valid;
   logic [DATA_W-1:0]             r_pc_wr_data;
   logic                          r_wr_conflict;
   logic [NUM_DATA-1:0]           w_busy;
   logic                          w_wa_pc;
   logic                          w_wb_pc;
   logic [NUM_RD-1:0][DATA_W-1:0] w_rd_data;
   logic [NUM_RD-1:0]             w_rd_ready;

   assign w_wa_pc = bus.wa_en && (bus.wa_addr == PC_IDX);
   assign w_wb_pc = bus.wb_en && (bus.wb_addr == PC_IDX);

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) u_scoreboard (
      .i_clk      (clk),
      .i_rst_n    (rst),
      .i_iss_en   (bus.iss_en),
      .i_iss_addr (bus.iss_addr),
      .i_wa_en    (bus.wa_en),
      .i_wa_addr  (bus.wa_addr),
      .i_wb_en    (bus.wb_en),
      .i_wb_addr  (bus.wb_addr),
      .o_busy     (w_busy)
   );

   // Data array writes; port A wins when both ports hit the same register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NUM_DATA; i++)
            r_regs[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_DATA; i++) begin
            if (bus.wa_en && (bus.wa_addr == ADDR_W'(i)))
               r_regs[i] <= bus.wa_data;
            else if (bus.wb_en && (bus.wb_addr == ADDR_W'(i)))
               r_regs[i] <= bus.wb_data;
         end
      end
   end

   // One-cycle PC redirect and same-address conflict pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc_wr_valid <= 1'b0;
         r_pc_wr_data  <= '0;
         r_wr_conflict <= 1'b0;
      end else begin
         r_pc_wr_valid <= w_wa_pc || w_wb_pc;
         r_pc_wr_data  <= w_wa_pc ? bus.wa_data : (w_wb_pc ? bus.wb_data : '0);
         r_wr_conflict <= bus.wa_en && bus.wb_en && (bus.wa_addr == bus.wb_addr) &&
                          (bus.wa_addr != PC_IDX);
      end
   end

   // NZCV status register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_flags <= '0;
      else if (bus.flags_we)
         r_flags <= bus.flags_in;
   end

   // Combinational read ports; addresses above the PC alias read as zero/ready.
   always_comb begin
      w_rd_data  = '0;
      w_rd_ready = '1;
      for (int unsigned p = 0; p < NUM_RD; p++) begin
         if (bus.rd_addr[p] == PC_IDX) begin
            w_rd_data[p] = bus.pc_in + DATA_W'(PC_OFFSET);
         end else if (bus.rd_addr[p] < PC_IDX) begin
            w_rd_data[p]  = r_regs[bus.rd_addr[p]];
            w_rd_ready[p] = !w_busy[bus.rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
            // B is checked first so that A overrides it on a shared address.
            if (bus.wb_en && (bus.wb_addr == bus.rd_addr[p])) begin
               w_rd_data[p]  = bus.wb_data;
               w_rd_ready[p] = 1'b1;
            end
            if (bus.wa_en && (bus.wa_addr == bus.rd_addr[p])) begin
               w_rd_data[p]  = bus.wa_data;
               w_rd_ready[p] = 1'b1;
            end
`endif
         end
      end
   end

   assign bus.rd_data     = w_rd_data;
   assign bus.rd_ready    = w_rd_ready;
   assign bus.flags_out   = r_flags;
   assign bus.pc_wr_valid = r_pc_wr_valid;
   assign bus.pc_wr_data  = r_pc_wr_data;
   assign bus.wr_conflict = r_wr_conflict;
endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp (default 32x16, 3 read ports, offset 8).
module tb_register_file_mp;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   register_file_mp_if #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(3)) bus ();

   register_file_mp #(
      .DATA_W    (32),
      .NUM_REGS  (16),
      .NUM_RD    (3),
      .PC_OFFSET (8)
   ) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
      bus.rd_addr[0] = a0;
      bus.rd_addr[1] = a1;
      bus.rd_addr[2] = a2;
   endtask

   task automatic idle();
      bus.wa_en    = 1'b0;
      bus.wa_addr  = '0;
      bus.wa_data  = '0;
      bus.wb_en    = 1'b0;
      bus.wb_addr  = '0;
      bus.wb_data  = '0;
      bus.iss_en   = 1'b0;
      bus.iss_addr = '0;
      bus.flags_we = 1'b0;
      bus.flags_in = '0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      idle();
      bus.pc_in = '0;
      set_rd(4'd0, 4'd0, 4'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset state across every data register and all ports
      for (int a = 0; a < 15; a++) begin
         set_rd(4'(a), 4'(a), 4'(a));
         #1;
         for (int p = 0; p < 3; p++) begin
            chk("rst_rd_data", bus.rd_data[p], 32'h0);
            chk("rst_rd_ready", 32'(bus.rd_ready[p]), 32'h1);
         end
      end
      chk("rst_flags", 32'(bus.flags_out), 32'h0);
      chk("rst_pc_wr_valid", 32'(bus.pc_wr_valid), 32'h0);
      chk("rst_pc_wr_data", bus.pc_wr_data, 32'h0);
      chk("rst_wr_conflict", 32'(bus.wr_conflict), 32'h0);

      // Two writes to different registers
      bus.wa_en = 1'b1; bus.wa_addr = 4'd3; bus.wa_data = 32'hDEADBEEF;
      bus.wb_en = 1'b1; bus.wb_addr = 4'd5; bus.wb_data = 32'h12345678;
      step();
      idle();
      set_rd(4'd3, 4'd5, 4'd0);
      #1;
      chk("wr_r3", bus.rd_data[0], 32'hDEADBEEF);
      chk("wr_r5", bus.rd_data[1], 32'h12345678);
      chk("wr_r0_untouched", bus.rd_data[2], 32'h0);
      chk("wr_no_conflict", 32'(bus.wr_conflict), 32'h0);
      chk("wr_no_redirect", 32'(bus.pc_wr_valid), 32'h0);

      // Same-address conflict: A wins, one-cycle pulse
      bus.wa_en = 1'b1; bus.wa_addr = 4'd7; bus.wa_data = 32'hAAAA0000;
      bus.wb_en = 1'b1; bus.wb_addr = 4'd7; bus.wb_data = 32'h0000BBBB;
      step();
      idle();
      set_rd(4'd7, 4'd3, 4'd5);
      #1;
      chk("conf_r7", bus.rd_data[0], 32'hAAAA0000);
      chk("conf_pulse", 32'(bus.wr_conflict), 32'h1);
      step();
      chk("conf_pulse_end", 32'(bus.wr_conflict), 32'h0);
      chk("conf_r7_hold", bus.rd_data[0], 32'hAAAA0000);

      // PC alias read-through, including wrap-around
      bus.pc_in = 32'h100;
      set_rd(4'd15, 4'd15, 4'd15);
      #1;
      chk("pc_read", bus.rd_data[0], 32'h108);
      chk("pc_read_ready", 32'(bus.rd_ready[2]), 32'h1);
      bus.pc_in = 32'hFFFFFFFC;
      #1;
      chk("pc_read_wrap", bus.rd_data[1], 32'h4);

      // Port A writes the PC alias
      bus.wa_en = 1'b1; bus.wa_addr = 4'd15; bus.wa_data = 32'h200;
      step();
      idle();
      set_rd(4'd3, 4'd5, 4'd7);
      #1;
      chk("redir_valid", 32'(bus.pc_wr_valid), 32'h1);
      chk("redir_data", bus.pc_wr_data, 32'h200);
      chk("redir_r3", bus.rd_data[0], 32'hDEADBEEF);
      chk("redir_r5", bus.rd_data[1], 32'h12345678);
      chk("redir_r7", bus.rd_data[2], 32'hAAAA0000);
      step();
      chk("redir_valid_end", 32'(bus.pc_wr_valid), 32'h0);
      chk("redir_data_end", bus.pc_wr_data, 32'h0);

      // Both ports write the PC alias: A wins, no conflict pulse
      bus.wa_en = 1'b1; bus.wa_addr = 4'd15; bus.wa_data = 32'h300;
      bus.wb_en = 1'b1; bus.wb_addr = 4'd15; bus.wb_data = 32'h400;
      step();
      idle();
      chk("redir2_valid", 32'(bus.pc_wr_valid), 32'h1);
      chk("redir2_data", bus.pc_wr_data, 32'h300);
      chk("redir2_no_conflict", 32'(bus.wr_conflict), 32'h0);

      // Port B alone writes the PC alias
      bus.wb_en = 1'b1; bus.wb_addr = 4'd15; bus.wb_data = 32'h500;
      step();
      idle();
      chk("redir3_data", bus.pc_wr_data, 32'h500);

      // Scoreboard: issue, issue+write same edge, later write clears
      bus.iss_en = 1'b1; bus.iss_addr = 4'd4;
      step();
      idle();
      set_rd(4'd4, 4'd15, 4'd3);
      #1;
      chk("sb_busy", 32'(bus.rd_ready[0]), 32'h0);
      chk("sb_pc_ready", 32'(bus.rd_ready[1]), 32'h1);
      chk("sb_other_ready", 32'(bus.rd_ready[2]), 32'h1);
      bus.iss_en = 1'b1; bus.iss_addr = 4'd4;
      bus.wa_en = 1'b1; bus.wa_addr = 4'd4; bus.wa_data = 32'h44;
      step();
      idle();
      #1;
      chk("sb_set_wins", 32'(bus.rd_ready[0]), 32'h0);
      chk("sb_set_wins_data", bus.rd_data[0], 32'h44);
      bus.wb_en = 1'b1; bus.wb_addr = 4'd4; bus.wb_data = 32'h4444;
      #1;
      chk("sb_pre_edge_ready", 32'(bus.rd_ready[0]), BYP ? 32'h1 : 32'h0);
      chk("sb_pre_edge_data", bus.rd_data[0], BYP ? 32'h4444 : 32'h44);
      step();
      idle();
      #1;
      chk("sb_clear", 32'(bus.rd_ready[0]), 32'h1);
      chk("sb_clear_data", bus.rd_data[0], 32'h4444);

      // Same-cycle write while reading a busy register
      bus.iss_en = 1'b1; bus.iss_addr = 4'd2;
      step();
      idle();
      set_rd(4'd2, 4'd2, 4'd2);
      bus.wa_en = 1'b1; bus.wa_addr = 4'd2; bus.wa_data = 32'h55;
      bus.wb_en = 1'b1; bus.wb_addr = 4'd2; bus.wb_data = 32'h66;
      #1;
      chk("byp_data", bus.rd_data[0], BYP ? 32'h55 : 32'h0);
      chk("byp_ready", 32'(bus.rd_ready[1]), BYP ? 32'h1 : 32'h0);
      step();
      idle();
      #1;
      chk("post_write_r2", bus.rd_data[2], 32'h55);
      chk("post_write_r2_ready", 32'(bus.rd_ready[2]), 32'h1);

      // Flags update and hold
      bus.flags_we = 1'b1; bus.flags_in = 4'hA;
      step();
      idle();
      bus.flags_in = 4'h5;
      #1;
      chk("flags_upd", 32'(bus.flags_out), 32'hA);
      step();
      chk("flags_hold", 32'(bus.flags_out), 32'hA);

      // Reset mid-operation with redirect and busy pending
      bus.wa_en = 1'b1; bus.wa_addr = 4'd15; bus.wa_data = 32'h600;
      bus.iss_en = 1'b1; bus.iss_addr = 4'd9;
      step();
      idle();
      set_rd(4'd3, 4'd9, 4'd7);
      #1;
      chk("pre_rst_redir", 32'(bus.pc_wr_valid), 32'h1);
      chk("pre_rst_busy", 32'(bus.rd_ready[1]), 32'h0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_redir", 32'(bus.pc_wr_valid), 32'h0);
      chk("mid_rst_redir_data", bus.pc_wr_data, 32'h0);
      chk("mid_rst_r3", bus.rd_data[0], 32'h0);
      chk("mid_rst_ready", 32'(bus.rd_ready[1]), 32'h1);
      chk("mid_rst_r7", bus.rd_data[2], 32'h0);
      chk("mid_rst_flags", 32'(bus.flags_out), 32'h0);
      bus.wa_en = 1'b1; bus.wa_addr = 4'd6; bus.wa_data = 32'h66;
      step();
      rst_n = 1'b1;
      idle();
      set_rd(4'd6, 4'd6, 4'd6);
      #1;
      chk("rst_write_lost", bus.rd_data[0], 32'h0);
      step();
      chk("rst_write_lost_after", bus.rd_data[1], 32'h0);
      chk("rst_no_redir", 32'(bus.pc_wr_valid), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
